// File: rtl/mem_ctrl_pkg.sv
// Shared types and memory geometry for the 16x32 memory controller slice.
package mem_ctrl_pkg;

  localparam int unsigned MEM_DEPTH  = 16;
  localparam int unsigned MEM_ADDR_W = 4;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB,
    CMD,
    RDWAIT,
    RESP
  } arb_state_e;

endpackage

// File: rtl/mem16_32_rr_arbiter_rr_pick.sv
// Combinational round-robin pick.
// Ports: req (request vector), last_grant (previous winner),
//        grant (one-hot winner), grant_idx (encoded winner).
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;
  int unsigned    start;
  int unsigned    pos;
  logic           found;

  // Rotating the doubled vector puts last_grant+1 at bit 0, so a plain
  // lowest-set-bit search gives the round-robin winner.
  always_comb begin
    dbl       = {req, req};
    start     = (32'(last_grant) >= N - 1) ? 0 : 32'(last_grant) + 1;
    rot       = dbl >> start;
    found     = 1'b0;
    pos       = 0;
    grant     = '0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = (start + k >= N) ? start + k - N : start + k;
      end
    end
    if (found) begin
      grant_idx        = IDX_W'(pos);
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mem16_32_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing the single memory16_32 port.
// Ports: i_mem_clk/i_mem_rst_n clock and async active-low reset;
//        i_req_* per-requester request fields, o_req_ready accept pulse;
//        o_rsp_valid/o_rsp_rdata completion; o_mem_* memory command;
//        i_mem_rdata registered memory read data; o_busy not in ARB.
module mem16_32_rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = MEM_DATA_W
) (
  input  logic                      i_mem_clk,
  input  logic                      i_mem_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_rdata,
  output logic                      o_mem_en,
  output logic                      o_mem_wr_en,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  output logic                      o_busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state;
  arb_state_e         state_d;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick;
  logic               accept;
  logic               lat_wr;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (i_req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .grant_idx  (pick_idx)
  );

  always_ff @(posedge i_mem_clk or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      state <= ARB;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    o_req_ready = '0;
    accept      = 1'b0;
    case (state)
      ARB: begin
        if (|i_req_valid) begin
          o_req_ready = pick;
          accept      = 1'b1;
          state_d     = CMD;
        end
      end
      CMD:     state_d = lat_wr ? RESP : RDWAIT;
      RDWAIT:  state_d = RESP;
      RESP:    state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // The o_mem_* registers double as the latched request fields; last_grant
  // doubles as the latched winner index used for the response pulse.
  always_ff @(posedge i_mem_clk or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      last_grant  <= IDX_W'(NUM_REQ - 1);
      lat_wr      <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_wr_en <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_rsp_valid <= '0;
      o_rsp_rdata <= '0;
    end else begin
      o_mem_en    <= 1'b0;
      o_mem_wr_en <= 1'b0;
      o_rsp_valid <= '0;
      case (state)
        ARB: begin
          if (accept) begin
            last_grant  <= pick_idx;
            lat_wr      <= i_req_wr[pick_idx];
            o_mem_en    <= 1'b1;
            o_mem_wr_en <= i_req_wr[pick_idx];
            o_mem_addr  <= i_req_addr[int'(pick_idx) * int'(ADDR_W) +: ADDR_W];
            o_mem_wdata <= i_req_wdata[int'(pick_idx) * int'(DATA_W) +: DATA_W];
          end
        end
        CMD: begin
          if (lat_wr) begin
            o_rsp_valid[last_grant] <= 1'b1;
            o_rsp_rdata             <= '0;
          end
        end
        RDWAIT: begin
          o_rsp_valid[last_grant] <= 1'b1;
          o_rsp_rdata             <= i_mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != ARB);

endmodule

// File: tb/tb_mem16_32_rr_arbiter.sv
module tb_mem16_32_rr_arbiter;

  localparam int NR = 4;
  localparam int AW = 4;
  localparam int DW = 32;

  typedef struct {
    int             req;
    bit             wr;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } op_t;

  typedef struct {
    int             req;
    logic [DW-1:0]  rdata;
    int             due;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     i_req_valid = '0;
  logic [NR-1:0]     i_req_wr = '0;
  logic [NR*AW-1:0]  i_req_addr = '0;
  logic [NR*DW-1:0]  i_req_wdata = '0;
  logic [NR-1:0]     o_req_ready;
  logic [NR-1:0]     o_rsp_valid;
  logic [DW-1:0]     o_rsp_rdata;
  logic              o_mem_en;
  logic              o_mem_wr_en;
  logic [AW-1:0]     o_mem_addr;
  logic [DW-1:0]     o_mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;
  logic              o_busy;

  always #5 clk = ~clk;

  mem16_32_rr_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .i_mem_clk   (clk),
    .i_mem_rst_n (rst_n),
    .i_req_valid (i_req_valid),
    .i_req_wr    (i_req_wr),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_wr_en (o_mem_wr_en),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_busy      (o_busy)
  );

  // Behavioural memory16_32: registered read, one cycle after the strobe.
  logic [DW-1:0] mem_arr [16] = '{default: '0};
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_wr_en) mem_arr[o_mem_addr] <= o_mem_wdata;
      else             mem_rdata <= mem_arr[o_mem_addr];
    end
  end

  logic [DW-1:0] ref_mem [16] = '{default: '0};
  int            n_assert = 0;
  int            n_fail = 0;
  int            cyc = 0;
  op_t           pend_q[$];
  rsp_t          sb_q[$];
  int            grant_log[$];
  int            grant_cyc[$];
  logic [NR-1:0] acc = '0;
  int            m_lg = NR - 1;
  int            busy_left = 0;
  int            cmd_cyc = -1;
  bit            cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  int            waitc [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [NR-1:0] rr_exp(input logic [NR-1:0] v, input int lg);
    logic [NR-1:0] g = '0;
    bit            f = 1'b0;
    for (int i = 1; i <= NR; i++) begin
      int k = (lg + i) % NR;
      if (!f && v[k]) begin
        g[k] = 1'b1;
        f    = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    acc       = '0;
    m_lg      = NR - 1;
    busy_left = 0;
    cmd_cyc   = -1;
    for (int j = 0; j < NR; j++) waitc[j] = 0;
  endtask

  task automatic push_op(input int req, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    op_t op;
    op.req  = req;
    op.wr   = wr;
    op.addr = addr;
    op.data = data;
    pend_q.push_back(op);
  endtask

  // Accepted requesters drop valid; idle requesters pick up their next op.
  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      if (acc[k]) begin
        i_req_valid[k] = 1'b0;
        acc[k]         = 1'b0;
      end
      if (!i_req_valid[k]) begin
        for (int i = 0; i < pend_q.size(); i++) begin
          if (pend_q[i].req == k) begin
            i_req_valid[k]           = 1'b1;
            i_req_wr[k]              = pend_q[i].wr;
            i_req_addr[k*AW +: AW]   = pend_q[i].addr;
            i_req_wdata[k*DW +: DW]  = pend_q[i].data;
            pend_q.delete(i);
            break;
          end
        end
      end
    end
  endtask

  task automatic record_accept(input int k);
    rsp_t r;
    bit   wr;
    acc[k] = 1'b1;
    wr     = i_req_wr[k];
    for (int j = 0; j < NR; j++) begin
      if (j != k && i_req_valid[j]) begin
        waitc[j]++;
        chk("starvation_bound", 64'(waitc[j] <= NR - 1), 64'd1);
      end else begin
        waitc[j] = 0;
      end
    end
    cmd_cyc  = cyc + 1;
    cmd_wr   = wr;
    cmd_addr = i_req_addr[k*AW +: AW];
    cmd_data = i_req_wdata[k*DW +: DW];
    r.req    = k;
    r.rdata  = wr ? '0 : ref_mem[cmd_addr];
    r.due    = cyc + (wr ? 2 : 3);
    if (wr) ref_mem[cmd_addr] = cmd_data;
    sb_q.push_back(r);
    m_lg      = k;
    busy_left = wr ? 2 : 3;
    grant_log.push_back(k);
    grant_cyc.push_back(cyc);
  endtask

  task automatic check();
    logic [NR-1:0] er;
    bit            exp_busy;
    rsp_t          r;
    chk("ready_onehot0", 64'($onehot0(o_req_ready)), 64'd1);
    chk("rsp_onehot0", 64'($onehot0(o_rsp_valid)), 64'd1);
    exp_busy = (busy_left > 0);
    chk("busy", o_busy, exp_busy);
    if (busy_left > 0) busy_left--;
    er = exp_busy ? '0 : rr_exp(i_req_valid, m_lg);
    chk("req_ready", o_req_ready, er);
    for (int k = 0; k < NR; k++) if (er[k]) record_accept(k);
    if (cmd_cyc == cyc) begin
      chk("mem_en", o_mem_en, 1'b1);
      chk("mem_wr_en", o_mem_wr_en, cmd_wr);
      chk("mem_addr", o_mem_addr, cmd_addr);
      if (cmd_wr) chk("mem_wdata", o_mem_wdata, cmd_data);
    end else begin
      chk("mem_en_idle", o_mem_en, 1'b0);
    end
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      r = sb_q.pop_front();
      chk("rsp_valid", o_rsp_valid, NR'(1) << r.req);
      chk("rsp_rdata", o_rsp_rdata, r.rdata);
    end else begin
      chk("rsp_idle", o_rsp_valid, '0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check();
    cyc++;
  endtask

  function automatic bit is_idle();
    return pend_q.size() == 0 && i_req_valid == '0 && sb_q.size() == 0 && busy_left == 0;
  endfunction

  task automatic run_idle(input int budget);
    int n = 0;
    while (!is_idle() && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_within_budget", 64'(is_idle()), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, o_req_ready, '0);
    chk({tag, "_rsp_valid"}, o_rsp_valid, '0);
    chk({tag, "_rsp_rdata"}, o_rsp_rdata, '0);
    chk({tag, "_mem_en"}, o_mem_en, 1'b0);
    chk({tag, "_mem_wr_en"}, o_mem_wr_en, 1'b0);
    chk({tag, "_mem_addr"}, o_mem_addr, '0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, '0);
    chk({tag, "_busy"}, o_busy, 1'b0);
  endtask

  task automatic chk_order(input string tag, input int exp_q[$], input int gap);
    chk({tag, "_count"}, grant_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++) begin
      chk({tag, "_grant"}, grant_log[i], exp_q[i]);
      if (gap > 0 && i > 0) chk({tag, "_spacing"}, grant_cyc[i] - grant_cyc[i-1], gap);
    end
  endtask

  initial begin
    int log_n;
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single write, then read-back from another requester
    push_op(0, 1'b1, 4'd3, 32'hDEADBEEF);
    run_idle(50);
    push_op(2, 1'b0, 4'd3, '0);
    run_idle(50);
    chk("readback_ref", ref_mem[3], 32'hDEADBEEF);

    // Fill addr k from requester k, then all four read concurrently
    for (int k = 0; k < NR; k++) begin
      push_op(k, 1'b1, AW'(k), 32'hA5A50000 + 32'(k * 17));
      run_idle(50);
    end
    grant_log.delete();
    grant_cyc.delete();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++) push_op(k, 1'b0, AW'(k), '0);
    run_idle(100);
    chk_order("all_valid_reads", '{0, 1, 2, 3, 0, 1, 2, 3}, 4);

    // last_grant=1 with req1 and req3 pending: 3 then 1
    push_op(1, 1'b1, 4'd9, 32'h11112222);
    run_idle(50);
    grant_log.delete();
    grant_cyc.delete();
    push_op(1, 1'b0, 4'd9, '0);
    push_op(3, 1'b0, 4'd9, '0);
    run_idle(50);
    chk_order("lg1_skip", '{3, 1}, 4);

    // last_grant=3 with req0 and req3 pending: wrap to 0 first
    push_op(3, 1'b1, 4'd10, 32'h33334444);
    run_idle(50);
    grant_log.delete();
    grant_cyc.delete();
    push_op(0, 1'b1, 4'd11, 32'h55556666);
    push_op(3, 1'b0, 4'd10, '0);
    run_idle(50);
    chk_order("lg3_wrap", '{0, 3}, 3);

    // Reset during RDWAIT of a read by req1
    log_n = grant_log.size();
    push_op(1, 1'b0, 4'd3, '0);
    n = 0;
    while (grant_log.size() == log_n && n < 50) begin
      cycle();
      n++;
    end
    chk("rst_read_accepted", 64'(grant_log.size() > log_n), 64'd1);
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    push_op(1, 1'b1, 4'd5, 32'hCAFEF00D);
    repeat (2) begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      chk("in_reset_rsp_valid", o_rsp_valid, '0);
      chk("in_reset_mem_en", o_mem_en, 1'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check();
    cyc++;
    chk("post_reset_first_grant", grant_log[$], 1);
    chk("post_reset_grant_cycle", grant_cyc[$], cyc - 1);
    run_idle(50);

    // Random traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      push_op($urandom_range(0, NR - 1), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15)), $urandom);
      if (i % 8 == 7) repeat ($urandom_range(0, 12)) cycle();
    end
    run_idle(10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
